// File: rtl/jogo_desafio_memoria_pkg.sv
// rtl/jogo_desafio_memoria_pkg.sv - shared states, timing, pattern ROMs and limits for the memory game
package jogo_desafio_memoria_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA         = 4'h2,
    ESPERA_MOSTRA  = 4'h3,
    PROXIMA_MOSTRA = 4'h4,
    ESPERA_JOGADA  = 4'h5,
    REGISTRA       = 4'h6,
    COMPARA        = 4'h7,
    PROXIMA_JOGADA = 4'h8,
    PROXIMA_RODADA = 4'h9,
    FINAL_ACERTO   = 4'hA,
    FINAL_TIMEOUT  = 4'hD,
    FINAL_ERRO     = 4'hE
  } estado_t;

  localparam int T_SHOW_DEF    = 500;
  localparam int T_GAP_DEF     = 500;
  localparam int T_TIMEOUT_DEF = 3000;

  localparam logic [3:0] LIMITE_FACIL   = 4'd3;
  localparam logic [3:0] LIMITE_DIFICIL = 4'd15;

  // Entry 0 is the rightmost nibble.
  localparam logic [15:0][3:0] ROM_A = {4{4'b1000, 4'b0100, 4'b0010, 4'b0001}};
  localparam logic [15:0][3:0] ROM_B = {4{4'b1000, 4'b0010, 4'b0100, 4'b0001}};

  function automatic logic [3:0] rom_dado(input logic sel, input logic [3:0] addr);
    return sel ? ROM_B[addr] : ROM_A[addr];
  endfunction

endpackage

// File: rtl/jogo_desafio_memoria_hexa7seg.sv
// rtl/jogo_desafio_memoria_hexa7seg.sv - 4-bit hex to active-low seven-segment (gfedcba)
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = 7'h00;
    case (hexa)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  assign display = ~w_seg;

endmodule

// File: rtl/jogo_desafio_memoria.sv
// rtl/jogo_desafio_memoria.sv - Simon-style memory game top; JOGADA_ECHO_EN echoes botoes on leds while waiting for moves
module jogo_desafio_memoria
  import jogo_desafio_memoria_pkg::*;
#(
  parameter int T_SHOW    = T_SHOW_DEF,
  parameter int T_GAP     = T_GAP_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       chaveMemoria,
  input  logic       botaoDificuldade,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_limite,
  output logic       db_clock,
  output logic       db_igual,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_dificuldade,
  output logic       db_sel_memoria,
  output logic [1:0] db_selMux
);

  localparam logic [3:0] S_INICIAL        = INICIAL;
  localparam logic [3:0] S_PREPARACAO     = PREPARACAO;
  localparam logic [3:0] S_MOSTRA         = MOSTRA;
  localparam logic [3:0] S_ESPERA_MOSTRA  = ESPERA_MOSTRA;
  localparam logic [3:0] S_PROXIMA_MOSTRA = PROXIMA_MOSTRA;
  localparam logic [3:0] S_ESPERA_JOGADA  = ESPERA_JOGADA;
  localparam logic [3:0] S_REGISTRA       = REGISTRA;
  localparam logic [3:0] S_COMPARA        = COMPARA;
  localparam logic [3:0] S_PROXIMA_JOGADA = PROXIMA_JOGADA;
  localparam logic [3:0] S_PROXIMA_RODADA = PROXIMA_RODADA;
  localparam logic [3:0] S_FINAL_ACERTO   = FINAL_ACERTO;
  localparam logic [3:0] S_FINAL_TIMEOUT  = FINAL_TIMEOUT;
  localparam logic [3:0] S_FINAL_ERRO     = FINAL_ERRO;

  localparam int T_MAX_AB = (T_SHOW > T_GAP) ? T_SHOW : T_GAP;
  localparam int T_MAX    = (T_MAX_AB > T_TIMEOUT) ? T_MAX_AB : T_TIMEOUT;
  localparam int TW       = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] FIM_SHOW    = TW'(T_SHOW - 1);
  localparam logic [TW-1:0] FIM_GAP     = TW'(T_GAP - 1);
  localparam logic [TW-1:0] FIM_TIMEOUT = TW'(T_TIMEOUT - 1);

  logic [3:0]    r_estado;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_contagem;
  logic [3:0]    r_rodada;
  logic [3:0]    r_limite;
  logic [3:0]    r_jogada;
  logic          r_jogar_d;
  logic          r_botoes_nz_d;
  logic          r_dificuldade;
  logic          r_sel_memoria;

  logic          w_jogar_borda;
  logic          w_tem_jogada;
  logic [3:0]    w_dado;
  logic          w_igual;
  logic [1:0]    w_sel_mux;

  assign w_jogar_borda = jogar & ~r_jogar_d;
  assign w_tem_jogada  = (|botoes) & ~r_botoes_nz_d;
  assign w_dado        = rom_dado(r_sel_memoria, r_contagem);
  assign w_igual       = (r_jogada == w_dado);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado      <= S_INICIAL;
      r_timer       <= '0;
      r_contagem    <= '0;
      r_rodada      <= '0;
      r_limite      <= '0;
      r_jogada      <= '0;
      r_jogar_d     <= 1'b0;
      r_botoes_nz_d <= 1'b0;
      r_dificuldade <= 1'b0;
      r_sel_memoria <= 1'b0;
    end else begin
      r_jogar_d     <= jogar;
      r_botoes_nz_d <= |botoes;
      case (r_estado)
        S_INICIAL, S_FINAL_ACERTO, S_FINAL_ERRO, S_FINAL_TIMEOUT: begin
          if (w_jogar_borda) begin
            r_sel_memoria <= chaveMemoria;
            r_dificuldade <= botaoDificuldade;
            r_limite      <= botaoDificuldade ? LIMITE_DIFICIL : LIMITE_FACIL;
            r_rodada      <= '0;
            r_contagem    <= '0;
            r_timer       <= '0;
            r_estado      <= S_PREPARACAO;
          end
        end
        S_PREPARACAO: begin
          r_rodada   <= '0;
          r_contagem <= '0;
          r_timer    <= '0;
          r_estado   <= S_MOSTRA;
        end
        S_MOSTRA: begin
          if (r_timer == FIM_SHOW) begin
            r_timer  <= '0;
            r_estado <= S_ESPERA_MOSTRA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ESPERA_MOSTRA: begin
          if (r_timer == FIM_GAP) begin
            r_timer <= '0;
            if (r_contagem == r_rodada) begin
              r_contagem <= '0;
              r_estado   <= S_ESPERA_JOGADA;
            end else begin
              r_estado <= S_PROXIMA_MOSTRA;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_PROXIMA_MOSTRA: begin
          r_contagem <= r_contagem + 4'd1;
          r_estado   <= S_MOSTRA;
        end
        S_ESPERA_JOGADA: begin
          // A move on the very last allowed cycle still wins over the timeout.
          if (w_tem_jogada) begin
            r_jogada <= botoes;
            r_estado <= S_REGISTRA;
          end else if (r_timer == FIM_TIMEOUT) begin
            r_estado <= S_FINAL_TIMEOUT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_REGISTRA: r_estado <= S_COMPARA;
        S_COMPARA: begin
          if (!w_igual)                    r_estado <= S_FINAL_ERRO;
          else if (r_contagem != r_rodada) r_estado <= S_PROXIMA_JOGADA;
          else if (r_rodada == r_limite)   r_estado <= S_FINAL_ACERTO;
          else                             r_estado <= S_PROXIMA_RODADA;
        end
        S_PROXIMA_JOGADA: begin
          r_contagem <= r_contagem + 4'd1;
          r_timer    <= '0;
          r_estado   <= S_ESPERA_JOGADA;
        end
        S_PROXIMA_RODADA: begin
          r_rodada   <= r_rodada + 4'd1;
          r_contagem <= '0;
          r_timer    <= '0;
          r_estado   <= S_MOSTRA;
        end
        default: r_estado <= S_INICIAL;
      endcase
    end
  end

  always_comb begin
    w_sel_mux = 2'b00;
    if (r_estado == S_MOSTRA) w_sel_mux = 2'b10;
`ifdef JOGADA_ECHO_EN
    if (r_estado == S_ESPERA_JOGADA) w_sel_mux = 2'b01;
`else
    if (r_estado == S_ESPERA_JOGADA) w_sel_mux = 2'b00;
`endif
  end

  always_comb begin
    leds = 4'b0000;
    case (w_sel_mux)
      2'b10:   leds = w_dado;
      2'b01:   leds = botoes;
      default: leds = 4'b0000;
    endcase
  end

  assign ganhou         = (r_estado == S_FINAL_ACERTO);
  assign perdeu         = (r_estado == S_FINAL_ERRO) || (r_estado == S_FINAL_TIMEOUT);
  assign pronto         = ganhou || perdeu;
  assign timeout        = (r_estado == S_FINAL_TIMEOUT);
  assign db_clock       = clock;
  assign db_igual       = w_igual;
  assign db_iniciar     = jogar;
  assign db_tem_jogada  = w_tem_jogada;
  assign db_dificuldade = r_dificuldade;
  assign db_sel_memoria = r_sel_memoria;
  assign db_selMux      = w_sel_mux;

  hexa7seg u_hex_contagem (.hexa(r_contagem), .display(db_contagem));
  hexa7seg u_hex_memoria  (.hexa(w_dado),     .display(db_memoria));
  hexa7seg u_hex_estado   (.hexa(r_estado),   .display(db_estado));
  hexa7seg u_hex_jogada   (.hexa(r_jogada),   .display(db_jogadafeita));
  hexa7seg u_hex_limite   (.hexa(r_rodada),   .display(db_limite));

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// tb/tb_jogo_desafio_memoria.sv - randomized game-level model bench for jogo_desafio_memoria
module tb_jogo_desafio_memoria;

  localparam int TS = 6;
  localparam int TG = 5;
  localparam int TT = 40;

  logic       clock = 1'b0;
  logic       reset, jogar, chaveMemoria, botaoDificuldade;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, timeout;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
  logic       db_clock, db_igual, db_iniciar, db_tem_jogada, db_dificuldade, db_sel_memoria;
  logic [1:0] db_selMux;

  always #5 clock = ~clock;

  jogo_desafio_memoria #(.T_SHOW(TS), .T_GAP(TG), .T_TIMEOUT(TT)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .chaveMemoria(chaveMemoria),
    .botaoDificuldade(botaoDificuldade), .botoes(botoes), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_jogadafeita(db_jogadafeita), .db_limite(db_limite), .db_clock(db_clock),
    .db_igual(db_igual), .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
    .db_dificuldade(db_dificuldade), .db_sel_memoria(db_sel_memoria), .db_selMux(db_selMux)
  );

  int vectors = 0;
  int miscompares = 0;

  logic       exp_valid = 1'b0;
  logic [3:0] exp_st, exp_leds, exp_round;
  logic [1:0] exp_sm;
  logic       exp_dif, exp_sel;
  logic [3:0] cur_st, cur_round;
  int         bhold = 0;
  int         jhold = 0;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] rom(input logic sel, input int k);
    case (k % 4)
      0:       return 4'b0001;
      1:       return sel ? 4'b0100 : 4'b0010;
      2:       return sel ? 4'b0010 : 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_valid) begin
      chk("leds", 32'(leds), 32'(exp_leds));
      chk("db_estado", 32'(db_estado), 32'(seg(exp_st)));
      chk("ganhou", 32'(ganhou), 32'(exp_st == 4'hA));
      chk("perdeu", 32'(perdeu), 32'(exp_st == 4'hE || exp_st == 4'hD));
      chk("pronto", 32'(pronto), 32'(exp_st == 4'hA || exp_st == 4'hE || exp_st == 4'hD));
      chk("timeout", 32'(timeout), 32'(exp_st == 4'hD));
      chk("selMux", 32'(db_selMux), 32'(exp_sm));
      chk("db_limite", 32'(db_limite), 32'(seg(exp_round)));
      chk("db_dificuldade", 32'(db_dificuldade), 32'(exp_dif));
      chk("db_sel_memoria", 32'(db_sel_memoria), 32'(exp_sel));
    end
  end

  task automatic cyc(input logic [3:0] st, input logic [3:0] ld, input logic [1:0] sm, input logic [3:0] rnd);
    exp_st = st; exp_leds = ld; exp_sm = sm; exp_round = rnd; exp_valid = 1'b1;
    @(posedge clock); #1;
    if (bhold > 0) begin bhold--; if (bhold == 0) botoes = 4'b0000; end
    if (jhold > 0) begin jhold--; if (jhold == 0) jogar = 1'b0; end
  endtask

  task automatic fin(input logic [3:0] st, input logic [3:0] rnd);
    cur_st = st; cur_round = rnd;
    repeat ($urandom_range(3, 8)) cyc(st, 4'b0000, 2'b00, rnd);
  endtask

  task automatic start(input logic sel, input logic dif);
    chaveMemoria = sel; botaoDificuldade = dif;
    jogar = 1'b1; jhold = $urandom_range(1, 4);
    cyc(cur_st, 4'b0000, 2'b00, cur_round);
    exp_sel = sel; exp_dif = dif;
    cyc(4'h1, 4'b0000, 2'b00, 4'h0);
  endtask

  // modo: 0 win, 1 wrong move at (f_rod, f_item), 2 timeout at (f_rod, f_item)
  task automatic jogo(input logic sel, input logic dif, input int modo, input int f_rod, input int f_item);
    int lim;
    int d;
    logic wrong;
    logic [3:0] other;
    lim = dif ? 15 : 3;
    start(sel, dif);
    for (int r = 0; r <= lim; r++) begin
      for (int k = 0; k <= r; k++) begin
        for (int j = 0; j < TS; j++) begin
          if (j == 1 && k == 0 && bhold == 0 && $urandom_range(0, 3) == 0) begin
            botoes = 4'(1 << $urandom_range(0, 3)); bhold = 2;
          end
          if (j == 2 && r > 0 && jhold == 0 && $urandom_range(0, 3) == 0) begin
            jogar = 1'b1; jhold = 1;
          end
          cyc(4'h2, rom(sel, k), 2'b10, 4'(r));
        end
        repeat (TG) cyc(4'h3, 4'b0000, 2'b00, 4'(r));
        if (k < r) cyc(4'h4, 4'b0000, 2'b00, 4'(r));
      end
      for (int k = 0; k <= r; k++) begin
        if (modo == 2 && r == f_rod && k == f_item) begin
          repeat (TT) cyc(4'h5, 4'b0000, 2'b00, 4'(r));
          fin(4'hD, 4'(r));
          return;
        end
        d = ($urandom_range(0, 4) == 0) ? TT - 1 : int'($urandom_range(0, 6));
        repeat (d) cyc(4'h5, 4'b0000, 2'b00, 4'(r));
        wrong = (modo == 1 && r == f_rod && k == f_item);
        other = rom(sel, k);
        if (wrong) repeat ($urandom_range(1, 3)) other = {other[2:0], other[3]};
        botoes = other; bhold = $urandom_range(1, 3);
        cyc(4'h5, 4'b0000, 2'b00, 4'(r));
        cyc(4'h6, 4'b0000, 2'b00, 4'(r));
        cyc(4'h7, 4'b0000, 2'b00, 4'(r));
        if (wrong) begin
          fin(4'hE, 4'(r));
          return;
        end
        if (k < r) cyc(4'h8, 4'b0000, 2'b00, 4'(r));
        else if (r == lim) begin
          fin(4'hA, 4'(r));
          return;
        end else cyc(4'h9, 4'b0000, 2'b00, 4'(r));
      end
    end
  endtask

  task automatic jogo_reset(input logic sel);
    start(sel, 1'b0);
    repeat (3) cyc(4'h2, rom(sel, 0), 2'b10, 4'h0);
    reset = 1'b0;
    exp_sel = 1'b0; exp_dif = 1'b0;
    cyc(4'h0, 4'b0000, 2'b00, 4'h0);
    chk("reset_mid_estado", 32'(db_estado), 32'h40);
    reset = 1'b1;
    cur_st = 4'h0; cur_round = 4'h0;
    repeat (3) cyc(4'h0, 4'b0000, 2'b00, 4'h0);
  endtask

  initial begin
    int lim, fr, fi;
    logic sel, dif;
    reset = 1'b0; jogar = 1'b0; botoes = 4'b0000; chaveMemoria = 1'b0; botaoDificuldade = 1'b0;
    exp_sel = 1'b0; exp_dif = 1'b0; cur_st = 4'h0; cur_round = 4'h0;
    @(posedge clock); #1;
    chk("rst_estado", 32'(db_estado), 32'h40);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_pronto", 32'(pronto), 32'h0);
    chk("rst_selMux", 32'(db_selMux), 32'h0);
    reset = 1'b1;
    repeat (20) cyc(4'h0, 4'b0000, 2'b00, 4'h0);

    jogo(1'b1, 1'b0, 2, 2, 2);
    chk("lit_timeout", 32'(timeout), 32'h1);
    chk("lit_estado_D", 32'(db_estado), 32'h21);

    jogo(1'b0, 1'b0, 0, 0, 0);
    chk("lit_ganhou", 32'(ganhou), 32'h1);
    chk("lit_estado_A", 32'(db_estado), 32'h08);

    jogo(1'b0, 1'b0, 1, 1, 1);
    chk("lit_erro_timeout", 32'(timeout), 32'h0);
    chk("lit_estado_E", 32'(db_estado), 32'h06);

    jogo_reset(1'b1);

    for (int g = 0; g < 10; g++) begin
      sel = 1'($urandom_range(0, 1));
      dif = (g == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      lim = dif ? 15 : 3;
      fr = $urandom_range(0, lim);
      fi = $urandom_range(0, fr);
      jogo(sel, dif, (g == 3) ? 0 : int'($urandom_range(0, 2)), fr, fi);
    end

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
